stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//  Parametrised BCD stopwatch/countdown core with programmable preset and lap FIFO.
//  Sits between the debounced button/switch inputs and the seven-seg FSM / leaderboard in top.
//  Adds mode latching, countdown expiry, clear and lap capture. Fraction precision is generic.
// PARAMETERS
//  CLK_HZ       100_000_000  input clock frequency, Hz
//  FRAC_DIGITS  3            fractional BCD digits, 1..3; tick rate = 10^FRAC_DIGITS Hz
//  LAP_DEPTH    4            lap FIFO entries, power of 2, >=2
//  (derived) TW = 4*(4+FRAC_DIGITS); TICK_DIV = CLK_HZ/10^FRAC_DIGITS (integer, >=2)
// PORTS
//  clock       in   1   system clock, all logic rising-edge
//  reset_n     in   1   asynchronous, active-low reset
//  start_stop  in   1   1-cycle pulse (debounced upstream): toggle run
//  up          in   1   level: 1 count up, 0 count down; latched on start
//  prog        in   1   level: program mode, honoured only in STOPPED
//  inc         in   1   1-cycle pulse: increment selected field in program mode
//  min_sel     in   1   level: 1 = inc targets minutes, 0 = seconds
//  clear       in   1   1-cycle pulse: time := 0, go STOPPED
//  lap         in   1   1-cycle pulse: push current t into lap FIFO
//  lap_rd      in   1   1-cycle pulse: pop lap FIFO head
//  t           out  TW  {MM[7:0], SS[7:0], FRAC[4*FRAC_DIGITS-1:0]}, BCD
//  running     out  1   1 in RUNNING
//  zero        out  1   1-cycle pulse on countdown reaching 0
//  lap_time    out  TW  FIFO head (valid when lap_valid)
//  lap_valid   out  1   FIFO non-empty
//  lap_full    out  1   FIFO holds LAP_DEPTH entries
//  lap_count   out  clog2(LAP_DEPTH)+1  entries held
// BEHAVIOUR
//  Reset: state STOPPED; t=0; running=0; zero=0; FIFO empty; lap_time=0; up latch=1; prescaler=0.
//  States: STOPPED, RUNNING, EXPIRED.
//   STOPPED->RUNNING on start_stop, unless latched-down and t==0 (ignored). Latch up here;
//   prescaler := 0, so first tick lands TICK_DIV cycles after the start pulse.
//   RUNNING->STOPPED on start_stop. t holds; prescaler holds.
//   RUNNING->EXPIRED when a down tick makes t==0. zero=1 that cycle only.
//   EXPIRED->STOPPED on any start_stop, clear or inc pulse. Pulse is consumed, no other effect.
//  Tick: prescaler counts 0..TICK_DIV-1 in RUNNING; one tick on wrap; t updates same edge.
//  Up arithmetic: BCD ripple FRAC->SS(00..59)->MM(00..99).
//   99:59.(9..9) + 1 -> 00:00.(0..0); keeps running, no zero pulse.
//  Down arithmetic: BCD borrow ripple; SS borrows 59. Never decrements below 0.
//  Program mode: STOPPED and prog=1. inc adds 1 to MM (99->00) or SS (59->00);
//   no carry between fields; FRAC unchanged. inc outside program mode ignored.
//  clear: any state -> STOPPED, t=0, prescaler=0. FIFO untouched.
//   clear beats start_stop/inc/tick in the same cycle.
//  lap: pushes t as registered before that edge. Accepted in any state.
//  FIFO: FWFT; lap_time = oldest entry; lap_time = 0 when empty.
//   Push when full and no pop: dropped, contents unchanged.
//   Pop when empty: ignored.
//   Push+pop same cycle: both occur, count unchanged, including when full.
//  Outputs registered; t changes 1 cycle after tick/inc/clear edge. running tracks state, no lag.
//  Reset mid-run: everything returns to reset values immediately; lap contents lost.
// TESTING (CLK_HZ=1000, FRAC_DIGITS=2 -> TICK_DIV=10, LAP_DEPTH=4)
//  1. Reset, up=1, start, run 6000 ticks -> t=01:00.00, running=1; start_stop -> t holds 01:00.00.
//  2. Preset 99:59.99 via prog/inc, start up, 1 tick -> t=00:00.00, zero never asserts.
//  3. prog, min_sel=0, 2x inc; up=0, start; after 200 ticks -> t=00:00.00,
//     zero high exactly 1 cycle, state EXPIRED; start_stop -> STOPPED, still 0.
//  4. Down mode, t=0, start_stop -> running stays 0; inc while running -> t unchanged.
//  5. 5 lap pulses at 00:01.00 .. 00:05.00 -> count=4, lap_full=1, head=00:01.00;
//     lap+lap_rd same cycle -> count=4, head=00:02.00; 4 pops -> lap_valid=0.
//  6. clear and start_stop same cycle while running -> t=0, running=0;
//     reset_n low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_core.sv
// BCD stopwatch / countdown core with a programmable MM:SS preset and a lap-capture FIFO.
// Time is {MM, SS, FRAC}, all BCD. One tick every TICK_DIV clocks while running.
module stopwatch_lap_fifo #(
  parameter int TW    = 28,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] dout,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   count
);
  logic [DEPTH-1:0][TW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     do_push, do_pop;

  // A pop frees the slot a same-cycle push needs, so push is allowed when full if popping.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

module stopwatch_core #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int FRAC_DIGITS = 3,
  parameter int LAP_DEPTH   = 4,
  localparam int TW         = 4*(4+FRAC_DIGITS),
  localparam int LCW        = $clog2(LAP_DEPTH)+1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start_stop,
  input  logic           up,
  input  logic           prog,
  input  logic           inc,
  input  logic           min_sel,
  input  logic           clear,
  input  logic           lap,
  input  logic           lap_rd,
  output logic [TW-1:0]  t,
  output logic           running,
  output logic           zero,
  output logic [TW-1:0]  lap_time,
  output logic           lap_valid,
  output logic           lap_full,
  output logic [LCW-1:0] lap_count
);
  localparam int ND       = 4 + FRAC_DIGITS;
  localparam int TICK_DIV = CLK_HZ / (10**FRAC_DIGITS);
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SS_LSB   = 4*FRAC_DIGITS;
  localparam int MM_LSB   = SS_LSB + 8;
  localparam int SS_HI    = FRAC_DIGITS + 1;

  typedef enum logic [1:0] {ST_STOPPED, ST_RUNNING, ST_EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] t_q, t_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          up_lat, up_nxt;
  logic          zero_q, zero_nxt;
  logic          tick;

  function automatic logic [3:0] dig_max(int i);
    return (i == SS_HI) ? 4'd5 : 4'd9;
  endfunction

  // One-count BCD ripple over the whole time word; the tens-of-seconds digit wraps at 5.
  function automatic logic [TW-1:0] bcd_step(logic [TW-1:0] v, logic down);
    logic [TW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (!down) begin
          if (r[4*i +: 4] == dig_max(i)) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = dig_max(i);
          else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Two-digit field increment for program mode; wraps without carrying out.
  function automatic logic [7:0] bcd2_inc(logic [7:0] f, logic [3:0] hi_max);
    if (f == {hi_max, 4'd9}) return 8'h00;
    if (f[3:0] == 4'd9)      return {f[7:4] + 4'd1, 4'd0};
    return {f[7:4], f[3:0] + 4'd1};
  endfunction

  assign tick = (presc == PW'(TICK_DIV-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_STOPPED;
      t_q    <= '0;
      presc  <= '0;
      up_lat <= 1'b1;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      t_q    <= t_nxt;
      presc  <= presc_nxt;
      up_lat <= up_nxt;
      zero_q <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    presc_nxt = presc;
    up_nxt    = up_lat;
    zero_nxt  = 1'b0;
    if (clear) begin
      state_nxt = ST_STOPPED;
      t_nxt     = '0;
      presc_nxt = '0;
    end else begin
      unique case (state)
        ST_STOPPED: begin
          if (start_stop) begin
            // A countdown from zero has nothing to do, so the start is dropped.
            if (up || (t_q != '0)) begin
              state_nxt = ST_RUNNING;
              up_nxt    = up;
              presc_nxt = '0;
            end
          end else if (prog && inc) begin
            if (min_sel) t_nxt[MM_LSB +: 8] = bcd2_inc(t_q[MM_LSB +: 8], 4'd9);
            else         t_nxt[SS_LSB +: 8] = bcd2_inc(t_q[SS_LSB +: 8], 4'd5);
          end
        end
        ST_RUNNING: begin
          if (start_stop) begin
            state_nxt = ST_STOPPED;
          end else if (tick) begin
            presc_nxt = '0;
            if (up_lat) begin
              t_nxt = bcd_step(t_q, 1'b0);
            end else if (t_q != '0) begin
              t_nxt = bcd_step(t_q, 1'b1);
              if (t_nxt == '0) begin
                state_nxt = ST_EXPIRED;
                zero_nxt  = 1'b1;
              end
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        ST_EXPIRED: begin
          if (start_stop || inc) state_nxt = ST_STOPPED;
        end
        default: state_nxt = ST_STOPPED;
      endcase
    end
  end

  assign t       = t_q;
  assign running = (state == ST_RUNNING);
  assign zero    = zero_q;

  stopwatch_lap_fifo #(.TW(TW), .DEPTH(LAP_DEPTH)) u_lap_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (lap),
    .pop     (lap_rd),
    .din     (t_q),
    .dout    (lap_time),
    .valid   (lap_valid),
    .full    (lap_full),
    .count   (lap_count)
  );
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at 1 kHz, two fraction digits, four lap slots.
// The reference model keeps time as plain centiseconds and laps in a queue.
module tb_stopwatch_core;
  localparam int TW  = 24;
  localparam int LCW = 3;
  localparam int M_STOP = 0, M_RUN = 1, M_EXP = 2;

  logic clock = 1'b0, reset_n = 1'b0;
  logic start_stop = 1'b0, up = 1'b1, prog = 1'b0, inc = 1'b0, min_sel = 1'b0;
  logic clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;
  logic [TW-1:0]  t, lap_time;
  logic           running, zero, lap_valid, lap_full;
  logic [LCW-1:0] lap_count;

  int n_checks = 0, n_fail = 0;

  // reference model state
  int m_st, m_t, m_pc;
  bit m_up, m_zero;
  int m_q[$];

  stopwatch_core #(.CLK_HZ(1000), .FRAC_DIGITS(2), .LAP_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start_stop(start_stop), .up(up), .prog(prog),
    .inc(inc), .min_sel(min_sel), .clear(clear), .lap(lap), .lap_rd(lap_rd),
    .t(t), .running(running), .zero(zero), .lap_time(lap_time),
    .lap_valid(lap_valid), .lap_full(lap_full), .lap_count(lap_count)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] to_bcd(int cs);
    int mm, ss, fr;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    fr = cs % 100;
    return {4'(mm/10), 4'(mm%10), 4'(ss/10), 4'(ss%10), 4'(fr/10), 4'(fr%10)};
  endfunction

  task automatic model_reset();
    m_st = M_STOP; m_t = 0; m_pc = 0; m_up = 1'b1; m_zero = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    int  old_t, s;
    bit  do_pop, do_push;
    old_t   = m_t;
    m_zero  = 1'b0;
    do_pop  = lap_rd && (m_q.size() != 0);
    do_push = lap && ((m_q.size() < 4) || do_pop);
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) m_q.push_back(old_t);
    if (clear) begin
      m_st = M_STOP; m_t = 0; m_pc = 0;
    end else if (m_st == M_STOP) begin
      if (start_stop) begin
        if (up || m_t != 0) begin m_st = M_RUN; m_up = up; m_pc = 0; end
      end else if (prog && inc) begin
        if (min_sel) m_t = (((m_t / 6000) + 1) % 100) * 6000 + (m_t % 6000);
        else begin
          s   = (m_t / 100) % 60;
          m_t = m_t - s*100 + ((s + 1) % 60) * 100;
        end
      end
    end else if (m_st == M_RUN) begin
      if (start_stop) m_st = M_STOP;
      else begin
        m_pc++;
        if (m_pc == 10) begin
          m_pc = 0;
          if (m_up) m_t = (m_t + 1) % 600000;
          else if (m_t > 0) begin
            m_t--;
            if (m_t == 0) begin m_st = M_EXP; m_zero = 1'b1; end
          end
        end
      end
    end else begin
      if (start_stop || inc) m_st = M_STOP;
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; clk1(); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; clk1(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #22;
    n_checks++;
    if (t !== '0 || running !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_core: t=%h running=%b zero=%b, need 0/0/0", t, running, zero);
    end
    n_checks++;
    if (lap_valid !== 1'b0 || lap_full !== 1'b0 || lap_count !== '0 || lap_time !== '0) begin
      n_fail++;
      $display("FAIL reset_fifo: valid=%b full=%b count=%0d head=%h, need all 0",
               lap_valid, lap_full, lap_count, lap_time);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    pulse_clear();
    up = 1'b1;
    pulse_ss();
    repeat (60000) clk1();
    n_checks++;
    if (t !== 24'h010000 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL count_up_6000: t=%h running=%b, need 010000/1", t, running);
    end
    pulse_ss();
    repeat (20) clk1();
    n_checks++;
    if (t !== 24'h010000 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_hold: t=%h running=%b, need 010000/0", t, running);
    end
  endtask

  task automatic test_wrap();
    int zero_seen;
    pulse_clear();
    up = 1'b1;
    pulse_ss();
    repeat (990) clk1();
    pulse_ss();
    n_checks++;
    if (t !== 24'h000099) begin
      n_fail++;
      $display("FAIL frac_99: t=%h, need 000099", t);
    end
    prog = 1'b1; min_sel = 1'b1; inc = 1'b1;
    repeat (99) clk1();
    min_sel = 1'b0;
    repeat (59) clk1();
    inc = 1'b0; prog = 1'b0;
    n_checks++;
    if (t !== 24'h995999) begin
      n_fail++;
      $display("FAIL preset_max: t=%h, need 995999", t);
    end
    zero_seen = 0;
    start_stop = 1'b1; clk1(); start_stop = 1'b0;
    if (zero) zero_seen++;
    repeat (10) begin clk1(); if (zero) zero_seen++; end
    n_checks++;
    if (t !== 24'h000000 || running !== 1'b1 || zero_seen != 0) begin
      n_fail++;
      $display("FAIL up_wrap: t=%h running=%b zero_cycles=%0d, need 000000/1/0",
               t, running, zero_seen);
    end
    pulse_ss();
  endtask

  task automatic test_countdown();
    int zero_cnt, zero_at;
    pulse_clear();
    prog = 1'b1; min_sel = 1'b0; inc = 1'b1;
    repeat (2) clk1();
    inc = 1'b0; prog = 1'b0;
    n_checks++;
    if (t !== 24'h000200) begin
      n_fail++;
      $display("FAIL preset_2s: t=%h, need 000200", t);
    end
    up = 1'b0;
    pulse_ss();
    zero_cnt = 0; zero_at = -1;
    for (int i = 1; i <= 2005; i++) begin
      clk1();
      if (zero) begin zero_cnt++; zero_at = i; end
      if (i == 2000) begin
        n_checks++;
        if (t !== '0 || running !== 1'b0 || zero !== 1'b1) begin
          n_fail++;
          $display("FAIL expire_edge: t=%h running=%b zero=%b, need 000000/0/1", t, running, zero);
        end
      end
    end
    n_checks++;
    if (zero_cnt != 1 || zero_at != 2000) begin
      n_fail++;
      $display("FAIL zero_pulse: cycles=%0d at=%0d, need 1 at 2000", zero_cnt, zero_at);
    end
    // from EXPIRED a start pulse only returns to STOPPED, even when counting up
    up = 1'b1;
    pulse_ss();
    repeat (15) clk1();
    n_checks++;
    if (running !== 1'b0 || t !== '0) begin
      n_fail++;
      $display("FAIL expired_exit: running=%b t=%h, need 0/000000", running, t);
    end
    prog = 1'b1; inc = 1'b1; clk1(); inc = 1'b0; prog = 1'b0;
    n_checks++;
    if (t !== 24'h000100) begin
      n_fail++;
      $display("FAIL stopped_after_exp: t=%h, need 000100", t);
    end
  endtask

  task automatic test_down_zero_and_inc();
    pulse_clear();
    up = 1'b0;
    pulse_ss();
    repeat (5) clk1();
    n_checks++;
    if (running !== 1'b0 || t !== '0) begin
      n_fail++;
      $display("FAIL down_from_zero: running=%b t=%h, need 0/000000", running, t);
    end
    up = 1'b1;
    pulse_ss();
    prog = 1'b1; min_sel = 1'b0; inc = 1'b1; clk1(); inc = 1'b0; prog = 1'b0;
    n_checks++;
    if (running !== 1'b1 || t !== '0) begin
      n_fail++;
      $display("FAIL inc_while_running: running=%b t=%h, need 1/000000", running, t);
    end
    pulse_ss();
  endtask

  task automatic test_lap_fifo();
    pulse_clear();
    up = 1'b1;
    pulse_ss();
    repeat (1000) clk1();
    for (int k = 1; k <= 5; k++) begin
      lap = 1'b1; clk1(); lap = 1'b0;
      if (k < 5) repeat (999) clk1();
    end
    pulse_ss();
    n_checks++;
    if (lap_count !== 3'd4 || lap_full !== 1'b1 || lap_valid !== 1'b1 || lap_time !== 24'h000100) begin
      n_fail++;
      $display("FAIL lap_full_drop: count=%0d full=%b valid=%b head=%h, need 4/1/1/000100",
               lap_count, lap_full, lap_valid, lap_time);
    end
    lap = 1'b1; lap_rd = 1'b1; clk1(); lap = 1'b0; lap_rd = 1'b0;
    n_checks++;
    if (lap_count !== 3'd4 || lap_full !== 1'b1 || lap_time !== 24'h000200) begin
      n_fail++;
      $display("FAIL lap_push_pop_full: count=%0d full=%b head=%h, need 4/1/000200",
               lap_count, lap_full, lap_time);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (lap_time !== to_bcd((k + 2) * 100)) begin
        n_fail++;
        $display("FAIL lap_head_%0d: head=%h, need %h", k, lap_time, to_bcd((k + 2) * 100));
      end
      lap_rd = 1'b1; clk1(); lap_rd = 1'b0;
    end
    n_checks++;
    if (lap_valid !== 1'b0 || lap_count !== '0 || lap_time !== '0) begin
      n_fail++;
      $display("FAIL lap_drained: valid=%b count=%0d head=%h, need 0/0/000000",
               lap_valid, lap_count, lap_time);
    end
    lap_rd = 1'b1; clk1(); lap_rd = 1'b0;
    n_checks++;
    if (lap_count !== '0 || lap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty: count=%0d valid=%b, need 0/0", lap_count, lap_valid);
    end
  endtask

  task automatic test_clear_and_reset();
    up = 1'b1;
    pulse_ss();
    repeat (57) clk1();
    clear = 1'b1; start_stop = 1'b1; clk1(); clear = 1'b0; start_stop = 1'b0;
    n_checks++;
    if (t !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_start: t=%h running=%b, need 000000/0", t, running);
    end
    pulse_ss();
    repeat (35) clk1();
    lap = 1'b1; clk1(); lap = 1'b0;
    repeat (3) clk1();
    n_checks++;
    if (t !== 24'h000003 || lap_valid !== 1'b1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: t=%h valid=%b running=%b, need 000003/1/1", t, lap_valid, running);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (t !== '0 || running !== 1'b0 || zero !== 1'b0 || lap_valid !== 1'b0 ||
        lap_full !== 1'b0 || lap_count !== '0 || lap_time !== '0) begin
      n_fail++;
      $display("FAIL async_reset: t=%h run=%b zero=%b valid=%b full=%b count=%0d head=%h, need all 0",
               t, running, zero, lap_valid, lap_full, lap_count, lap_time);
    end
    model_reset();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [23:0] exp_head;
    for (int c = 0; c < 4000; c++) begin
      start_stop = ($urandom_range(99) < 3);
      clear      = ($urandom_range(199) < 1);
      inc        = ($urandom_range(99) < 12);
      lap        = ($urandom_range(99) < 6);
      lap_rd     = ($urandom_range(99) < 5);
      min_sel    = $urandom_range(1);
      if ($urandom_range(99) < 3) up   = ~up;
      if ($urandom_range(99) < 4) prog = ~prog;
      clk1();
      exp_head = (m_q.size() != 0) ? to_bcd(m_q[0]) : 24'h0;
      n_checks++;
      if (t !== to_bcd(m_t) || running !== (m_st == M_RUN) || zero !== m_zero ||
          lap_valid !== (m_q.size() != 0) || lap_full !== (m_q.size() == 4) ||
          lap_count !== 3'(m_q.size()) || lap_time !== exp_head) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: t=%h/%h run=%b/%b zero=%b/%b count=%0d/%0d full=%b head=%h/%h",
                 c, t, to_bcd(m_t), running, (m_st == M_RUN), zero, m_zero,
                 lap_count, m_q.size(), lap_full, lap_time, exp_head);
      end
    end
    start_stop = 1'b0; clear = 1'b0; inc = 1'b0; lap = 1'b0; lap_rd = 1'b0; prog = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_down_zero_and_inc();
    test_lap_fifo();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
